// File: rtl/pixel_shadow_sink_pkg.sv
// Shared constants, FSM encoding and the xy-to-address helper for the pixel shadow sink.
package pixel_shadow_sink_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;
    localparam int CW      = 3;
    localparam int ADDR_W  = 15;
    localparam int DEPTH   = XSCREEN * YSCREEN;

    localparam logic [CW-1:0] CLEAR_COLOUR = 3'b000;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Linear address y*160 + x built from shifts: y*128 + y*32 + x.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] col, input logic [6:0] row);
        logic [ADDR_W-1:0] row_128;
        logic [ADDR_W-1:0] row_32;
        logic [ADDR_W-1:0] col_ext;
        row_128 = {1'b0, row, 7'd0};
        row_32  = {3'd0, row, 5'd0};
        col_ext = {7'd0, col};
        return row_128 + row_32 + col_ext;
    endfunction

endpackage

// File: rtl/pixel_shadow_sink_shadow_ram.sv
// Simple dual-port RAM: one write port, one enabled synchronous read port (1-cycle latency).
module shadow_ram
    import pixel_shadow_sink_pkg::*;
#(
    parameter int RAM_DEPTH = DEPTH,
    parameter int WIDTH     = CW,
    parameter int AW        = ADDR_W
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [RAM_DEPTH];

    // Write and read ports; rdata only changes on an enabled read so it holds between reads.
    // NOTE: the array has no reset so it maps onto block RAM; the owner clears it by writing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_shadow_sink.sv
// Shadow copy of the 160x120 plot bus with a 1-cycle-latency read-back port and self-clear.
module pixel_shadow_sink
    import pixel_shadow_sink_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          plot,
    input  logic [7:0]    x,
    input  logic [6:0]    y,
    input  logic [CW-1:0] colour,
    input  logic          rd_req,
    input  logic [7:0]    rd_x,
    input  logic [6:0]    rd_y,
    output logic          rd_valid,
    output logic [CW-1:0] rd_colour,
    output logic          busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic [ADDR_W-1:0]   clr_addr;
    logic                wr_in;
    logic                rd_in;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   rd_addr;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [CW-1:0]       ram_wdata;
    logic                ram_re;
    logic [CW-1:0]       ram_q;
    logic                byp_sel;
    logic [CW-1:0]       byp_data;

    // Bounds checks and address generation for both ports.
    always_comb begin
        wr_in   = (x < 8'(XSCREEN)) && (y < 7'(YSCREEN));
        rd_in   = (rd_x < 8'(XSCREEN)) && (rd_y < 7'(YSCREEN));
        wr_addr = xy_to_addr(x, y);
        rd_addr = xy_to_addr(rd_x, rd_y);
    end

    // RAM port steering: clear sweep owns the write port while clearing, plot bus otherwise.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = colour;
        ram_re    = 1'b0;
        if (!reset) begin
            if (state == CLEAR) begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr;
                ram_wdata = CLEAR_COLOUR;
            end else begin
                ram_we = plot && wr_in;
                ram_re = rd_req && rd_in;
            end
        end
    end

    shadow_ram #(
        .RAM_DEPTH (DEPTH),
        .WIDTH     (CW),
        .AW        (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // Control FSM: clear sweep, then run; also registers read status and bypass data.
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            rd_valid <= 1'b0;
            byp_sel  <= 1'b1;
            byp_data <= '0;
        end else if (state == CLEAR) begin
            rd_valid <= 1'b0;
            if (clr_addr == LAST_ADDR) begin
                state    <= RUN;
                busy     <= 1'b0;
                clr_addr <= '0;
            end else begin
                clr_addr <= clr_addr + ADDR_W'(1);
            end
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                if (!rd_in) begin
                    // Off-screen reads return the background colour.
                    byp_sel  <= 1'b1;
                    byp_data <= CLEAR_COLOUR;
                end else if (plot && wr_in && (wr_addr == rd_addr)) begin
                    // Write-first: the read sees the colour landing this same edge.
                    byp_sel  <= 1'b1;
                    byp_data <= colour;
                end else begin
                    byp_sel  <= 1'b0;
                end
            end
        end
    end

    assign rd_colour = byp_sel ? byp_data : ram_q;

endmodule

// File: tb/tb_pixel_shadow_sink.sv
// Self-checking bench: directed vector table, randomized traffic against an array model,
// and hand-written reset/clear sequences.
module tb_pixel_shadow_sink;
    import pixel_shadow_sink_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          plot = 1'b0;
    logic [7:0]    x = '0;
    logic [6:0]    y = '0;
    logic [CW-1:0] colour = '0;
    logic          rd_req = 1'b0;
    logic [7:0]    rd_x = '0;
    logic [6:0]    rd_y = '0;
    logic          rd_valid;
    logic [CW-1:0] rd_colour;
    logic          busy;

    pixel_shadow_sink dut (
        .clk       (clk),
        .reset     (reset),
        .plot      (plot),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .rd_req    (rd_req),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_valid  (rd_valid),
        .rd_colour (rd_colour),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference picture: one colour per screen pixel, row-major.
    logic [CW-1:0] model [XSCREEN*YSCREEN];
    logic [CW-1:0] last_col;

    typedef struct {
        string      name;
        logic       p;
        logic [7:0] wx;
        logic [6:0] wy;
        logic [2:0] wc;
        logic       r;
        logic [7:0] rx;
        logic [6:0] ry;
        logic       ev;
        logic [2:0] ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic p, int wx, int wy, int wc,
                                logic r, int rx, int ry, logic ev, int ec);
        vec_t v;
        v.name = name; v.p = p; v.wx = 8'(wx); v.wy = 7'(wy); v.wc = 3'(wc);
        v.r = r; v.rx = 8'(rx); v.ry = 7'(ry); v.ev = ev; v.ec = 3'(ec);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_clear();
        foreach (model[i]) model[i] = CLEAR_COLOUR;
        last_col = '0;
    endtask

    function automatic logic on_screen(input logic [7:0] cx, input logic [6:0] cy);
        return (int'(cx) < XSCREEN) && (int'(cy) < YSCREEN);
    endfunction

    // One run-mode cycle starting and ending at a negedge; returns the model's expected outputs.
    task automatic drive_cycle(input logic p, input logic [7:0] wx, input logic [6:0] wy,
                               input logic [2:0] wc, input logic r, input logic [7:0] rx,
                               input logic [6:0] ry, output logic mv, output logic [2:0] mc);
        plot = p; x = wx; y = wy; colour = wc;
        rd_req = r; rd_x = rx; rd_y = ry;
        if (p && on_screen(wx, wy)) model[int'(wy) * XSCREEN + int'(wx)] = wc;
        if (r) begin
            mv = 1'b1;
            mc = on_screen(rx, ry) ? model[int'(ry) * XSCREEN + int'(rx)] : CLEAR_COLOUR;
            last_col = mc;
        end else begin
            mv = 1'b0;
            mc = last_col;
        end
        @(posedge clk);
        @(negedge clk);
        plot = 1'b0;
        rd_req = 1'b0;
    endtask

    // Count busy cycles from the current negedge; pokes plot/rd_req at cycle 100 and
    // optionally pulses reset at cycle abort_at.
    task automatic wait_clear(input int abort_at, output int cnt, output int saw_valid);
        cnt = 0;
        saw_valid = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            cnt++;
            if (cnt == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                model_clear();
                return;
            end
            if (cnt == 100) begin
                plot = 1'b1; x = 8'd10; y = 7'd10; colour = 3'b001;
                rd_req = 1'b1; rd_x = 8'd10; rd_y = 7'd10;
            end else begin
                plot = 1'b0;
                rd_req = 1'b0;
            end
            @(negedge clk);
            if (rd_valid !== 1'b0) saw_valid++;
        end
        plot = 1'b0;
        rd_req = 1'b0;
    endtask

    function automatic logic [7:0] rnd_x();
        return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 200)) : 8'($urandom_range(0, 7));
    endfunction

    function automatic logic [6:0] rnd_y();
        return ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 7));
    endfunction

    initial begin
        int cnt;
        int saw;
        logic mv;
        logic [2:0] mc;

        vecs.push_back(mk("rd_0_0",      0,   0,   0, 0, 1,   0,   0, 1, 0));
        vecs.push_back(mk("rd_159_119",  0,   0,   0, 0, 1, 159, 119, 1, 0));
        vecs.push_back(mk("rd_80_60",    0,   0,   0, 0, 1,  80,  60, 1, 0));
        vecs.push_back(mk("rd_10_10",    0,   0,   0, 0, 1,  10,  10, 1, 0));
        vecs.push_back(mk("wr_30_30",    1,  30,  30, 4, 0,   0,   0, 0, 0));
        vecs.push_back(mk("rd_30_30",    0,   0,   0, 0, 1,  30,  30, 1, 4));
        vecs.push_back(mk("rd_31_30",    0,   0,   0, 0, 1,  31,  30, 1, 0));
        vecs.push_back(mk("bypass",      1,  80,  60, 2, 1,  80,  60, 1, 2));
        vecs.push_back(mk("wr_x_oob",    1, 160,   5, 7, 0,   0,   0, 0, 2));
        vecs.push_back(mk("wr_y_oob",    1,   5, 120, 7, 0,   0,   0, 0, 2));
        vecs.push_back(mk("rd_0_6",      0,   0,   0, 0, 1,   0,   6, 1, 0));
        vecs.push_back(mk("rd_5_0",      0,   0,   0, 0, 1,   5,   0, 1, 0));
        vecs.push_back(mk("rd_oob",      0,   0,   0, 0, 1, 200,  10, 1, 0));
        vecs.push_back(mk("held_a",      0,   0,   0, 0, 1,  30,  30, 1, 4));
        vecs.push_back(mk("held_b",      0,   0,   0, 0, 1,  80,  60, 1, 2));
        vecs.push_back(mk("wr_rd_diff",  1, 159, 119, 5, 1,   0,   0, 1, 0));
        vecs.push_back(mk("rd_corner",   0,   0,   0, 0, 1, 159, 119, 1, 5));

        // Reset held for two cycles.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(busy), 1);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_colour", int'(rd_colour), 0);
        reset = 1'b0;
        model_clear();

        // Initial clear, with plot/rd_req poked while busy.
        wait_clear(0, cnt, saw);
        check("clear_len", cnt, XSCREEN * YSCREEN);
        check("no_valid_while_busy", saw, 0);

        // Directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].p, vecs[i].wx, vecs[i].wy, vecs[i].wc,
                        vecs[i].r, vecs[i].rx, vecs[i].ry, mv, mc);
            check({vecs[i].name, "_valid"}, int'(rd_valid), int'(vecs[i].ev));
            check({vecs[i].name, "_colour"}, int'(rd_colour), int'(vecs[i].ec));
        end

        // Randomized traffic in a small window plus the screen edges.
        for (int i = 0; i < 400; i++) begin
            logic       p;
            logic       r;
            logic [7:0] wx;
            logic [6:0] wy;
            logic [7:0] rx;
            logic [6:0] ry;
            p  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 9) < 6);
            wx = rnd_x();
            wy = rnd_y();
            if ($urandom_range(0, 3) == 0) begin
                rx = wx; ry = wy;
            end else begin
                rx = rnd_x(); ry = rnd_y();
            end
            drive_cycle(p, wx, wy, 3'($urandom_range(0, 7)), r, rx, ry, mv, mc);
            check("rand_valid", int'(rd_valid), int'(mv));
            check("rand_colour", int'(rd_colour), int'(mc));
        end

        // Reset mid-run after a write, then again mid-clear at clear address 5000.
        drive_cycle(1'b1, 8'd50, 7'd50, 3'b110, 1'b0, 8'd0, 7'd0, mv, mc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        wait_clear(5001, cnt, saw);
        check("midclear_reached", cnt, 5001);
        check("midclear_no_valid", saw, 0);
        wait_clear(0, cnt, saw);
        check("reclear_len", cnt, XSCREEN * YSCREEN);
        drive_cycle(1'b0, 8'd0, 7'd0, 3'b000, 1'b1, 8'd50, 7'd50, mv, mc);
        check("after_reset_valid", int'(rd_valid), 1);
        check("after_reset_colour", int'(rd_colour), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
